// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: PC, next-PC selection, imem handshake and IF/ID register.
// Optional build macro PIPE_IF_SQUASH_EN annuls the delay slot on every redirect.
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  input  logic [1:0]  pcsource,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        dvalid
);

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_HELD = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_dpc4;
  logic [31:0] r_inst;
  logic        r_dvalid;
  logic        r_req;
  logic [31:0] r_addr;
  logic        r_redir_pend;
  logic [31:0] r_redir_pc;
  logic [31:0] r_buf;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_dpc4_nxt;
  logic [31:0] w_inst_nxt;
  logic        w_dvalid_nxt;
  logic        w_req_nxt;
  logic [31:0] w_addr_nxt;
  logic        w_pend_nxt;
  logic [31:0] w_redir_pc_nxt;
  logic [31:0] w_buf_nxt;

  logic        w_fire;
  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_seq_pc;
  logic        w_adv;
  logic [31:0] w_word;

  // A completion only counts while a request is actually outstanding.
  assign w_fire     = r_req & imem_ack;
  assign w_redirect = r_dvalid & ~wpcir & (pcsource != 2'b00);

  // Redirect target selection and the PC that follows the instruction now completing.
  always_comb begin
    case (pcsource)
      2'b01:   w_target = bpc;
      2'b10:   w_target = rpc;
      2'b11:   w_target = jpc;
      default: w_target = bpc;
    endcase
    if (w_redirect) begin
      w_seq_pc = w_target;
    end else if (r_redir_pend) begin
      w_seq_pc = r_redir_pc;
    end else begin
      w_seq_pc = r_pc + 32'd4;
    end
  end

  // Next-state, IF/ID and PC update logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_dpc4_nxt     = r_dpc4;
    w_inst_nxt     = r_inst;
    w_dvalid_nxt   = r_dvalid;
    w_pend_nxt     = r_redir_pend;
    w_redir_pc_nxt = r_redir_pc;
    w_buf_nxt      = r_buf;
    w_adv          = 1'b0;
    w_word         = r_buf;

    case (r_state)
      S_REQ: begin
        if (w_fire && !wpcir) begin
          w_adv  = 1'b1;
          w_word = imem_rdata;
        end else if (w_fire) begin
          w_buf_nxt   = imem_rdata;
          w_state_nxt = S_HELD;
        end else if (!wpcir) begin
          w_inst_nxt   = NOP_INST;
          w_dvalid_nxt = 1'b0;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_HELD: begin
        if (!wpcir) begin
          w_adv       = 1'b1;
          w_word      = r_buf;
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_HELD;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase

    // A redirect that finds no completing fetch is parked until the fetch lands.
    if (w_adv) begin
      w_pc_nxt   = w_seq_pc;
      w_pend_nxt = 1'b0;
      w_dpc4_nxt = r_pc + 32'd4;
`ifdef PIPE_IF_SQUASH_EN
      if (w_redirect || r_redir_pend) begin
        w_inst_nxt   = NOP_INST;
        w_dvalid_nxt = 1'b0;
      end else begin
        w_inst_nxt   = w_word;
        w_dvalid_nxt = 1'b1;
      end
`else
      w_inst_nxt   = w_word;
      w_dvalid_nxt = 1'b1;
`endif
    end else if (w_redirect) begin
      w_pend_nxt     = 1'b1;
      w_redir_pc_nxt = w_target;
    end else begin
      w_pend_nxt = r_redir_pend;
    end

    w_req_nxt  = (w_state_nxt == S_REQ);
    w_addr_nxt = w_req_nxt ? w_pc_nxt : 32'h0000_0000;
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_dpc4       <= 32'h0000_0000;
      r_inst       <= NOP_INST;
      r_dvalid     <= 1'b0;
      r_req        <= 1'b0;
      r_addr       <= 32'h0000_0000;
      r_redir_pend <= 1'b0;
      r_redir_pc   <= 32'h0000_0000;
      r_buf        <= 32'h0000_0000;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_dpc4       <= w_dpc4_nxt;
      r_inst       <= w_inst_nxt;
      r_dvalid     <= w_dvalid_nxt;
      r_req        <= w_req_nxt;
      r_addr       <= w_addr_nxt;
      r_redir_pend <= w_pend_nxt;
      r_redir_pc   <= w_redir_pc_nxt;
      r_buf        <= w_buf_nxt;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign pc        = r_pc;
  assign dpc4      = r_dpc4;
  assign inst      = r_inst;
  assign dvalid    = r_dvalid;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Self-checking bench for pipe_if_stage: directed scenarios plus a randomized run
// checked against a program-order model of the instruction stream entering decode.
module tb_pipe_if_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] bpc, jpc, rpc;
  logic [1:0]  pcsource;
  logic        wpcir;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] pc, dpc4, inst;
  logic        dvalid;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

`ifdef PIPE_IF_SQUASH_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  pipe_if_stage dut (
    .clock(clock), .reset(reset), .bpc(bpc), .jpc(jpc), .rpc(rpc),
    .pcsource(pcsource), .wpcir(wpcir), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .pc(pc), .dpc4(dpc4),
    .inst(inst), .dvalid(dvalid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_in(input logic wp, input logic [1:0] ps, input logic ak);
    wpcir      = wp;
    pcsource   = ps;
    imem_ack   = ak;
    imem_rdata = ak ? memw(imem_addr) : 32'hDEAD_BEEF;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(1'b0, 2'b00, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic stream_to(input logic [31:0] a);
    for (int i = 0; i < 64; i++) begin
      if (imem_addr == a) break;
      set_in(1'b0, 2'b00, 1'b1);
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    n_chk++; if (dpc4 !== 32'h0) begin n_err++; $display("FAIL reset_dpc4 got %h exp %h", dpc4, 32'h0); end
    n_chk++; if (inst !== NOP) begin n_err++; $display("FAIL reset_inst got %h exp %h", inst, NOP); end
    n_chk++; if (dvalid !== 1'b0) begin n_err++; $display("FAIL reset_dvalid got %b exp 0", dvalid); end
    n_chk++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_req got %b/%h exp 0/0", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    set_in(1'b0, 2'b00, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin n_err++; $display("FAIL stream_addr k=%0d got %b/%h exp 1/%h", k, imem_req, imem_addr, 32'(4 * k)); end
      n_chk++; if (dpc4 !== 32'(4 * k) || dvalid !== (k > 0)) begin n_err++; $display("FAIL stream_id k=%0d got %h/%b exp %h/%b", k, dpc4, dvalid, 32'(4 * k), (k > 0)); end
      set_in(1'b0, 2'b00, 1'b1);
      tick();
    end
  endtask

  task automatic test_delayed_ack();
    do_reset();
    set_in(1'b0, 2'b00, 1'b0);
    tick();
    for (int f = 0; f < 2; f++) begin
      for (int w = 0; w < 3; w++) begin
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * f)) begin n_err++; $display("FAIL wait_req f=%0d w=%0d got %b/%h", f, w, imem_req, imem_addr); end
        set_in(1'b0, 2'b00, w == 2);
        tick();
        if (w < 2) begin
          n_chk++; if (dvalid !== 1'b0 || inst !== NOP) begin n_err++; $display("FAIL wait_bubble f=%0d w=%0d got %b/%h exp 0/%h", f, w, dvalid, inst, NOP); end
        end else begin
          n_chk++; if (dvalid !== 1'b1 || inst !== memw(32'(4 * f))) begin n_err++; $display("FAIL wait_entry f=%0d got %b/%h exp 1/%h", f, dvalid, inst, memw(32'(4 * f))); end
        end
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_in(1'b0, 2'b00, 1'b0);
    tick();
    stream_to(32'h14);
    n_chk++; if (dpc4 !== 32'h14 || dvalid !== 1'b1) begin n_err++; $display("FAIL br_setup got %h/%b exp 14/1", dpc4, dvalid); end
    bpc = 32'h100;
    set_in(1'b0, 2'b01, 1'b1);
    tick();
    n_chk++; if (dpc4 !== 32'h18 || dvalid !== !SQ) begin n_err++; $display("FAIL br_slot got %h/%b exp 18/%b", dpc4, dvalid, !SQ); end
    n_chk++; if (inst !== (SQ ? NOP : memw(32'h14))) begin n_err++; $display("FAIL br_slot_inst got %h exp %h", inst, SQ ? NOP : memw(32'h14)); end
    n_chk++; if (imem_addr !== 32'h100 || pc !== 32'h100) begin n_err++; $display("FAIL br_target got %h/%h exp 100", imem_addr, pc); end
    set_in(1'b0, 2'b00, 1'b1);
    tick();
    n_chk++; if (dpc4 !== 32'h104 || dvalid !== 1'b1 || inst !== memw(32'h100)) begin n_err++; $display("FAIL br_after got %h/%b/%h exp 104/1/%h", dpc4, dvalid, inst, memw(32'h100)); end
  endtask

  task automatic test_redirect_pending();
    do_reset();
    set_in(1'b0, 2'b00, 1'b0);
    tick();
    stream_to(32'h14);
    jpc = 32'h200;
    set_in(1'b0, 2'b11, 1'b0);
    tick();
    n_chk++; if (dvalid !== 1'b0 || pc !== 32'h14 || imem_addr !== 32'h14) begin n_err++; $display("FAIL pend_wait got %b/%h/%h exp 0/14/14", dvalid, pc, imem_addr); end
    set_in(1'b0, 2'b00, 1'b0);
    tick();
    set_in(1'b0, 2'b00, 1'b1);
    tick();
    n_chk++; if (pc !== 32'h200 || imem_addr !== 32'h200) begin n_err++; $display("FAIL pend_pc got %h/%h exp 200", pc, imem_addr); end
    n_chk++; if (dpc4 !== 32'h18 || dvalid !== !SQ) begin n_err++; $display("FAIL pend_slot got %h/%b exp 18/%b", dpc4, dvalid, !SQ); end
    set_in(1'b0, 2'b00, 1'b1);
    tick();
    n_chk++; if (pc !== 32'h204 || dpc4 !== 32'h204 || inst !== memw(32'h200)) begin n_err++; $display("FAIL pend_clear got %h/%h/%h exp 204/204/%h", pc, dpc4, inst, memw(32'h200)); end
  endtask

  task automatic test_stall();
    do_reset();
    set_in(1'b0, 2'b00, 1'b0);
    tick();
    stream_to(32'h8);
    for (int c = 0; c < 2; c++) begin
      set_in(1'b1, 2'b00, c == 0);
      tick();
      n_chk++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_err++; $display("FAIL stall_req c=%0d got %b/%h exp 0/0", c, imem_req, imem_addr); end
      n_chk++; if (dpc4 !== 32'h8 || inst !== memw(32'h4) || dvalid !== 1'b1 || pc !== 32'h8) begin n_err++; $display("FAIL stall_hold c=%0d got %h/%h/%b/%h", c, dpc4, inst, dvalid, pc); end
    end
    set_in(1'b0, 2'b00, 1'b0);
    tick();
    n_chk++; if (dpc4 !== 32'hC || inst !== memw(32'h8) || dvalid !== 1'b1) begin n_err++; $display("FAIL stall_release got %h/%h/%b exp C/%h/1", dpc4, inst, dvalid, memw(32'h8)); end
    n_chk++; if (pc !== 32'hC || imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_err++; $display("FAIL stall_pc got %h/%b/%h exp C/1/C", pc, imem_req, imem_addr); end
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    set_in(1'b0, 2'b00, 1'b0);
    tick();
    stream_to(32'h10);
    reset = 1'b1;
    set_in(1'b0, 2'b00, 1'b1);
    tick();
    n_chk++; if (pc !== 32'h0 || dpc4 !== 32'h0 || inst !== NOP || dvalid !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL midrst_vals got %h/%h/%h/%b/%b", pc, dpc4, inst, dvalid, imem_req); end
    reset = 1'b0;
    set_in(1'b0, 2'b00, 1'b0);
    tick();
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || dvalid !== 1'b0) begin n_err++; $display("FAIL midrst_req got %b/%h/%b exp 1/0/0", imem_req, imem_addr, dvalid); end
  endtask

  task automatic test_wrap();
    do_reset();
    set_in(1'b0, 2'b00, 1'b0);
    tick();
    stream_to(32'h8);
    jpc = 32'hFFFF_FFFC;
    set_in(1'b0, 2'b11, 1'b1);
    tick();
    n_chk++; if (pc !== 32'hFFFF_FFFC || imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_top got %h/%h exp FFFFFFFC", pc, imem_addr); end
    set_in(1'b0, 2'b00, 1'b1);
    tick();
    n_chk++; if (pc !== 32'h0 || imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h/%h exp 0", pc, imem_addr); end
    n_chk++; if (dpc4 !== 32'h0 || inst !== memw(32'hFFFF_FFFC) || dvalid !== 1'b1) begin n_err++; $display("FAIL wrap_id got %h/%h/%b exp 0/%h/1", dpc4, inst, dvalid, memw(32'hFFFF_FFFC)); end
  endtask

  // Decode must see the program in order: sequential words, with the target
  // following the delay slot (or replacing it when slots are annulled).
  task automatic test_random();
    logic [31:0] next_exp, jmp_t, tgt, prev_dpc4, prev_inst;
    logic        jmp_v, prev_wp, prev_dv, prev_req, prev_ack, wp, ak;
    logic [1:0]  ps;
    int          lat, entries;
    do_reset();
    set_in(1'b0, 2'b00, 1'b0);
    tick();
    next_exp = 32'h0; jmp_v = 1'b0; jmp_t = 32'h0;
    prev_wp = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; prev_dv = 1'b0;
    prev_dpc4 = 32'h0; prev_inst = 32'h0;
    lat = $urandom_range(0, 3); entries = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_wp) begin
        n_chk++; if (dpc4 !== prev_dpc4 || inst !== prev_inst || dvalid !== prev_dv) begin n_err++; $display("FAIL rnd_hold cyc=%0d got %h/%h/%b exp %h/%h/%b", cyc, dpc4, inst, dvalid, prev_dpc4, prev_inst, prev_dv); end
      end else if (dvalid) begin
        entries++;
        n_chk++; if (dpc4 - 32'd4 !== next_exp || inst !== memw(next_exp)) begin n_err++; $display("FAIL rnd_entry cyc=%0d got %h/%h exp %h/%h", cyc, dpc4 - 32'd4, inst, next_exp, memw(next_exp)); end
        if (jmp_v) begin next_exp = jmp_t; jmp_v = 1'b0; end
        else next_exp = next_exp + 32'd4;
      end else begin
        n_chk++; if (inst !== NOP) begin n_err++; $display("FAIL rnd_bubble cyc=%0d got %h exp %h", cyc, inst, NOP); end
      end
      if (prev_req && !prev_ack) begin
        n_chk++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rnd_req_held cyc=%0d got %b exp 1", cyc, imem_req); end
      end
      n_chk++; if (imem_addr !== (imem_req ? pc : 32'h0)) begin n_err++; $display("FAIL rnd_addr cyc=%0d got %h exp %h", cyc, imem_addr, imem_req ? pc : 32'h0); end

      wp  = ($urandom_range(0, 3) == 0);
      ps  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bpc = $urandom & 32'hFFFF_FFFC;
      rpc = $urandom & 32'hFFFF_FFFC;
      jpc = $urandom & 32'hFFFF_FFFC;
      if (imem_req && lat == 0) ak = 1'b1;
      else begin ak = 1'b0; if (imem_req) lat--; end
      if (dvalid && !wp && ps != 2'b00) begin
        tgt = (ps == 2'b01) ? bpc : (ps == 2'b10) ? rpc : jpc;
        if (SQ) next_exp = tgt;
        else begin jmp_v = 1'b1; jmp_t = tgt; end
      end
      set_in(wp, ps, ak);
      prev_wp = wp; prev_req = imem_req; prev_ack = ak;
      prev_dpc4 = dpc4; prev_inst = inst; prev_dv = dvalid;
      tick();
      if (ak) lat = $urandom_range(0, 3);
    end
    n_chk++; if (entries < 300) begin n_err++; $display("FAIL rnd_progress got %0d entries exp >= 300", entries); end
  endtask

  initial begin
    reset = 1'b1; bpc = 32'h0; jpc = 32'h0; rpc = 32'h0;
    pcsource = 2'b00; wpcir = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    @(negedge clock);
    test_reset();
    test_stream();
    test_delayed_ack();
    test_branch();
    test_redirect_pending();
    test_stall();
    test_reset_midfetch();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_if_stage.md
Name: pipe_if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. It is the producer side of the IF/ID interface that the decode stage consumes.
- Owns the PC register, next-PC selection (pc+4 / branch / jr / jump), the instruction-memory request/acknowledge handshake, and the IF/ID pipeline register (dpc4, inst).
- Honours decode's stall (wpcir) and its redirects, which may arrive while a multi-cycle fetch is still outstanding.
- Delay-slot semantics by default.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0000, word written to IF/ID inst when a bubble is inserted (sll $0,$0,0).

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
bpc  in  32  branch target from decode
jpc  in  32  jump (j/jal) target from decode
rpc  in  32  jr target (forwarded rs value) from decode
pcsource  in  2  00 pc+4, 01 bpc, 10 rpc, 11 jpc; meaningful only when dvalid=1
wpcir  in  1  decode stall: 1 = hold PC and IF/ID this cycle
imem_req  out  1  fetch request, held high until imem_ack
imem_addr  out  32  fetch address (= pc while imem_req=1)
imem_rdata  in  32  instruction word, valid in the cycle imem_ack=1
imem_ack  in  1  one-cycle completion strobe; ack may come in the same cycle as req
pc  out  32  current fetch PC (debug/simulation)
dpc4  out  32  IF/ID: address of the instruction in ID, plus 4
inst  out  32  IF/ID: instruction word in ID
dvalid  out  1  IF/ID: 1 = inst is a real fetched instruction, 0 = bubble

Behaviour:
- One clock, synchronous active-high reset.
- Reset values: pc=RESET_PC, dpc4=0, inst=NOP_INST, dvalid=0, imem_req=0, state=REQ, redir_pend=0, redir_pc=0, buf=0.
- The first request is issued in the cycle after reset deasserts.
- "ID advances" = ~wpcir. "redirect" = dvalid & ~wpcir & (pcsource!=00).
- Target mux: 01→bpc, 10→rpc, 11→jpc.
- Redirect capture:
  - If a redirect occurs but the current fetch does not complete this cycle: redir_pend<=1, redir_pc<=target.
  - A new redirect while redir_pend=1 cannot occur (ID holds a bubble or the delay slot); treat it as overwrite.
- next_pc:
  - redirect this cycle → target;
  - else redir_pend → redir_pc;
  - else pc+4.
  - Evaluated at fetch completion; redir_pend clears on that completion.
- FSM states:
  - REQ:
    - imem_req=1, imem_addr=pc.
    - ack & ~wpcir: IF/ID<={pc+4, imem_rdata}, dvalid<=1, pc<=next_pc, stay REQ.
    - ack & wpcir: buf<=imem_rdata, IF/ID held, go HELD.
    - ~ack & ~wpcir: IF/ID<={dpc4, NOP_INST}, dvalid<=0 (bubble).
    - ~ack & wpcir: IF/ID held.
  - HELD:
    - imem_req=0.
    - ~wpcir: IF/ID<={pc+4, buf}, dvalid<=1, pc<=next_pc, go REQ.
    - wpcir: hold everything.
- Delay slot: the instruction fetched at branch_pc+4 always enters ID. The PC after it is the redirect target.
- pc arithmetic is modulo 2^32; wrap from FFFF_FFFC to 0000_0000 is silent.
- Reset mid-fetch: the outstanding request is abandoned. An ack arriving in the reset cycle is ignored.
- Memory is assumed to drop any in-flight ack after reset.
- imem_addr is 0 whenever imem_req=0.

Optional Feature:
PIPE_IF_SQUASH_EN
- Defined: annulled delay slot. On a redirect, the instruction completing in that cycle (or the buffered one) enters IF/ID as a bubble (inst=NOP_INST, dvalid=0). If no fetch completes that cycle, the next completion (the delay slot) is squashed.
  - A squashed fetch still updates pc to the target.
- Undefined: delay-slot semantics as above. No squash logic is present.

Test Plan:
- Reset then ack every cycle, pcsource=00, wpcir=0 → imem_addr 0,4,8,C on consecutive cycles; dpc4 follows 4,8,C one cycle later; dvalid=1 from the 2nd cycle.
- ack delayed 3 cycles per fetch → bubbles (inst=0, dvalid=0) for 2 cycles between instructions; imem_req held high through the wait.
- Branch at 0x10 in ID with pcsource=01, bpc=0x100, ack immediate → delay slot 0x14 enters ID; next imem_addr=0x100. With PIPE_IF_SQUASH_EN: 0x14 appears with dvalid=0.
- Redirect while fetch of 0x14 is pending (ack 2 cycles later), jpc=0x200 → redir_pend set; on ack, pc becomes 0x200; redir_pend clears.
- wpcir=1 for 2 cycles while ack arrives → state HELD, imem_req=0, IF/ID unchanged; on wpcir=0, buffered word enters ID and pc advances by 4.
- reset asserted during outstanding fetch with ack in the same cycle → outputs at reset values; next request is to RESET_PC; pc=FFFF_FFFC then fetch completes → pc wraps to 0.
